issue_sequencer: RTL

Issue sequencer between instruction fetch and the rapids datapath. Accepts one 32-bit instruction per valid/ready handshake, expands vector instructions into 1/2/4/8 per-element micro-ops with stepped register selects, and stalls issue on register hazards via a write-latency scoreboard. Pulses `program_counter_inc` when the final element of each instruction issues.

---
 rtl/issue_sequencer_pkg.sv | 42 ++++
 rtl/issue_sequencer_if.sv | 31 +++
 rtl/issue_sequencer_write_scoreboard.sv | 38 +++
 rtl/issue_sequencer.sv | 115 +++++++++++
 4 files changed

// File: rtl/issue_sequencer_pkg.sv
// Shared types and constants for the rapids issue path: instruction layout,
// register/op types, sequencer states and vector element count decoding.
package rapids_pkg;

   localparam int unsigned OP_LSB    = 29;
   localparam int unsigned OP_W      = 3;
   localparam int unsigned VCODE_LSB = 27;
   localparam int unsigned VCODE_W   = 2;
   localparam int unsigned FORM_LSB  = 26;
   localparam int unsigned A_LSB     = 22;
   localparam int unsigned B_LSB     = 18;
   localparam int unsigned Y1_LSB    = 14;
   localparam int unsigned Y2_LSB    = 10;
   localparam int unsigned REG_W     = 4;
   localparam int unsigned WR_LSB    = 8;
   localparam int unsigned WR_W      = 2;

   typedef logic [OP_W-1:0]  op_t;
   typedef logic [REG_W-1:0] reg_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_t;

   // Bits [31:8] of the instruction word; the low byte is never stored.
   typedef struct packed {
      op_t                 op;
      logic [VCODE_W-1:0]  vcode;
      logic                form;
      reg_t                a;
      reg_t                b;
      reg_t                y1;
      reg_t                y2;
      logic [WR_W-1:0]     write;
   } instr_t;

   function automatic logic [3:0] vcode_to_n(input logic [VCODE_W-1:0] vcode);
      return 4'd1 << vcode;
   endfunction

endpackage

// File: rtl/issue_sequencer_if.sv
// Fetch-side handshake plus issue bus of the sequencer.
interface issue_sequencer_if;
   import rapids_pkg::*;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic        flush;
   logic        issue_valid;
   op_t         issue_op;
   logic        issue_form;
   reg_t        issue_a;
   reg_t        issue_b;
   reg_t        issue_y1;
   reg_t        issue_y2;
   logic [1:0]  issue_write;
   logic        program_counter_inc;

   modport master (
      output in_valid, instruction, flush,
      input  in_ready, issue_valid, issue_op, issue_form, issue_a, issue_b,
             issue_y1, issue_y2, issue_write, program_counter_inc
   );

   modport slave (
      input  in_valid, instruction, flush,
      output in_ready, issue_valid, issue_op, issue_form, issue_a, issue_b,
             issue_y1, issue_y2, issue_write, program_counter_inc
   );

endinterface

// File: rtl/issue_sequencer_write_scoreboard.sv
// Write-latency scoreboard: a LAT-deep shift of register write masks whose OR
// marks registers with results still in flight.
module write_scoreboard
   import rapids_pkg::*;
#(
   parameter int unsigned LAT  = 2,
   parameter int unsigned NREG = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREG-1:0] set_mask_i,
   input  reg_t [3:0]      rd_sel_i,
   output logic [NREG-1:0] pending_o,
   output logic [3:0]      rd_pend_o
);

   logic [NREG-1:0] stage_q [LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < LAT; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= set_mask_i;
         for (int unsigned i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   always_comb begin
      pending_o = '0;
      for (int unsigned i = 0; i < LAT; i++) pending_o = pending_o | stage_q[i];
   end

   always_comb begin
      rd_pend_o = '0;
      for (int unsigned k = 0; k < 4; k++) rd_pend_o[k] = pending_o[rd_sel_i[k]];
   end

endmodule

// File: rtl/issue_sequencer.sv
// Issue sequencer: accepts instructions, expands vectors into per-element
// micro-ops and stalls on scoreboard hazards.
module issue_sequencer
   import rapids_pkg::*;
#(
   parameter int unsigned LAT  = 2,
   parameter int unsigned NREG = 16
) (
   input logic              clk,
   input logic              rst,
   issue_sequencer_if.slave bus
);

   seq_state_t      state_q, state_d;
   instr_t          instr_q, instr_d;
   logic [2:0]      e_q, e_d;
   reg_t [3:0]      sel;
   logic [3:0]      sel_pend;
   logic [NREG-1:0] dest_mask, set_mask, unused_pending;
   logic            hazard, last, issue, ready, pc_inc;
   logic            unused_low;

   assign unused_low = ^bus.instruction[WR_LSB-1:0];

   assign sel[0] = instr_q.a  + reg_t'({1'b0, e_q});
   assign sel[1] = instr_q.b  + reg_t'({1'b0, e_q});
   assign sel[2] = instr_q.y1 + reg_t'({1'b0, e_q});
   assign sel[3] = instr_q.y2 + reg_t'({1'b0, e_q});

   assign last = ({1'b0, e_q} == vcode_to_n(instr_q.vcode) - 4'd1);

   always_comb begin
      dest_mask = '0;
      for (int unsigned r = 0; r < NREG; r++)
         dest_mask[r] = (instr_q.write[0] && sel[2] == reg_t'(r)) ||
                        (instr_q.write[1] && sel[3] == reg_t'(r));
   end

   assign hazard = sel_pend[0] | sel_pend[1] |
                   (instr_q.write[0] & sel_pend[2]) |
                   (instr_q.write[1] & sel_pend[3]);

   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      e_d      = e_q;
      issue    = 1'b0;
      ready    = 1'b0;
      pc_inc   = 1'b0;
      set_mask = '0;
      if (bus.flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               ready = 1'b1;
               if (bus.in_valid) begin
                  instr_d = instr_t'(bus.instruction[31:WR_LSB]);
                  e_d     = '0;
                  state_d = RUN;
               end
            end
            RUN: begin
               if (!hazard) begin
                  issue    = 1'b1;
                  set_mask = dest_mask;
                  if (last) begin
                     pc_inc = 1'b1;
                     ready  = 1'b1;
                     e_d    = '0;
                     if (bus.in_valid) instr_d = instr_t'(bus.instruction[31:WR_LSB]);
                     else              state_d = IDLE;
                  end else begin
                     e_d = e_q + 3'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         instr_q <= '0;
         e_q     <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         e_q     <= e_d;
      end
   end

   write_scoreboard #(.LAT(LAT), .NREG(NREG)) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .set_mask_i (set_mask),
      .rd_sel_i   (sel),
      .pending_o  (unused_pending),
      .rd_pend_o  (sel_pend)
   );

   assign bus.in_ready            = ready;
   assign bus.issue_valid         = issue;
   assign bus.program_counter_inc = pc_inc;
   assign bus.issue_op            = instr_q.op;
   assign bus.issue_form          = instr_q.form;
   assign bus.issue_a             = sel[0];
   assign bus.issue_b             = sel[1];
   assign bus.issue_y1            = sel[2];
   assign bus.issue_y2            = sel[3];
   assign bus.issue_write         = instr_q.write;

endmodule
